// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - sequences program load, data load, core run and data dump
module cpu_run_controller #(
    parameter int IMEM_LEN_W = 10,
    parameter int DMEM_LEN_W = 11,
    parameter int CYC_W      = 32,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IMEM_LEN_W-1:0] imem_len,
    input  logic [DMEM_LEN_W-1:0] dmem_len,
    input  logic [CYC_W-1:0]      run_cycles,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [63:0]           ld_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [63:0]           dump_data,
    output logic                  cpu_rst_n,
    output logic [63:0]           imem_addr,
    output logic                  imem_wen,
    output logic [31:0]           imem_wdata,
    output logic [63:0]           dmem_addr,
    output logic                  dmem_wen,
    output logic                  dmem_ren,
    output logic [63:0]           dmem_wdata,
    input  logic [63:0]           dmem_rdata,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (IMEM_LEN_W > DMEM_LEN_W) ? IMEM_LEN_W : DMEM_LEN_W;
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [IMEM_LEN_W-1:0] imem_len_q, imem_len_d;
    logic [DMEM_LEN_W-1:0] dmem_len_q, dmem_len_d;
    logic [CYC_W-1:0]      run_cycles_q, run_cycles_d;
    logic [63:0]           dump_data_q, dump_data_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;

    logic             imem_last, dmem_last, run_last, dump_last;
    logic [IDX_W-1:0] idx_inc;
    state_t           after_load_i, after_load_d, after_run, from_idle;

    assign idx_inc   = idx_q + IDX_W'(1);
    assign imem_last = (idx_inc == IDX_W'(imem_len_q));
    assign dmem_last = (idx_inc == IDX_W'(dmem_len_q));
    assign dump_last = dmem_last;
    assign run_last  = (cyc_q == run_cycles_q - CYC_W'(1));

    // Phase ordering: each phase skips ahead past any later phase with zero length.
    always_comb begin
        after_run    = (dmem_len_q != '0) ? S_DUMP_RD : S_DONE;
        after_load_d = (run_cycles_q != '0) ? S_RUN : S_DUMP_RD;
        if (dmem_len_q != '0)        after_load_i = S_LOAD_D;
        else if (run_cycles_q != '0) after_load_i = S_RUN;
        else                         after_load_i = S_DONE;
        if (imem_len != '0)          from_idle = S_LOAD_I;
        else if (dmem_len != '0)     from_idle = S_LOAD_D;
        else if (run_cycles != '0)   from_idle = S_RUN;
        else                         from_idle = S_DONE;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (start) state_d = from_idle;
                S_LOAD_I:    if (ld_valid && imem_last) state_d = after_load_i;
                S_LOAD_D:    if (ld_valid && dmem_last) state_d = after_load_d;
                S_RUN:       if (run_last) state_d = after_run;
                S_DUMP_RD:   state_d = S_DUMP_WAIT;
                S_DUMP_WAIT: if (lat_q == LAT_LAST) state_d = S_DUMP_OUT;
                S_DUMP_OUT:  if (dump_ready) state_d = dump_last ? S_DONE : S_DUMP_RD;
                S_DONE:      state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx_q        <= '0;
            cyc_q        <= '0;
            lat_q        <= '0;
            imem_len_q   <= '0;
            dmem_len_q   <= '0;
            run_cycles_q <= '0;
            dump_data_q  <= '0;
            cpu_rst_n_q  <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            cyc_q        <= cyc_d;
            lat_q        <= lat_d;
            imem_len_q   <= imem_len_d;
            dmem_len_q   <= dmem_len_d;
            run_cycles_q <= run_cycles_d;
            dump_data_q  <= dump_data_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
        end
    end

    always_comb begin
        idx_d        = idx_q;
        cyc_d        = cyc_q;
        lat_d        = lat_q;
        imem_len_d   = imem_len_q;
        dmem_len_d   = dmem_len_q;
        run_cycles_d = run_cycles_q;
        dump_data_d  = dump_data_q;
        cpu_rst_n_d  = (state_d == S_RUN);
        if (abort) begin
            idx_d = '0;
            cyc_d = '0;
            lat_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    idx_d = '0;
                    cyc_d = '0;
                    lat_d = '0;
                    if (start) begin
                        imem_len_d   = imem_len;
                        dmem_len_d   = dmem_len;
                        run_cycles_d = run_cycles;
                    end
                end
                S_LOAD_I:   if (ld_valid) idx_d = imem_last ? '0 : idx_inc;
                S_LOAD_D:   if (ld_valid) idx_d = dmem_last ? '0 : idx_inc;
                S_RUN:      cyc_d = run_last ? '0 : cyc_q + CYC_W'(1);
                S_DUMP_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        lat_d       = '0;
                        dump_data_d = dmem_rdata;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                S_DUMP_OUT: if (dump_ready) idx_d = dump_last ? '0 : idx_inc;
                default: ;
            endcase
        end
    end

    // Memory strobes are suppressed during abort so an aborted run never writes.
    always_comb begin
        ld_ready   = 1'b0;
        dump_valid = 1'b0;
        imem_wen   = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        dmem_wen   = 1'b0;
        dmem_ren   = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        done       = 1'b0;
        case (state_q)
            S_LOAD_I: begin
                ld_ready = 1'b1;
                if (ld_valid && !abort) begin
                    imem_wen   = 1'b1;
                    imem_addr  = {{(62-IDX_W){1'b0}}, idx_q, 2'b00};
                    imem_wdata = ld_data[31:0];
                end
            end
            S_LOAD_D: begin
                ld_ready = 1'b1;
                if (ld_valid && !abort) begin
                    dmem_wen   = 1'b1;
                    dmem_addr  = {{(61-IDX_W){1'b0}}, idx_q, 3'b000};
                    dmem_wdata = ld_data;
                end
            end
            S_DUMP_RD: begin
                if (!abort) begin
                    dmem_ren  = 1'b1;
                    dmem_addr = {{(61-IDX_W){1'b0}}, idx_q, 3'b000};
                end
            end
            S_DUMP_OUT: dump_valid = 1'b1;
            S_DONE:     done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign dump_data = dump_data_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule
